// File: rtl/hex_ascii_pkg.sv
// Shared ASCII constants and FSM state type for the hex ASCII streamer.
// HEX_STREAM_CRLF_EN adds the CR and LF states.
package hex_ascii_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;

`ifdef HEX_STREAM_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_CR,
        ST_LF
    } state_t;
`else
    typedef enum logic {
        ST_IDLE,
        ST_DIGITS
    } state_t;
`endif

endpackage

// File: rtl/hex_ascii_streamer_if.sv
// Value-capture and character-stream handshakes of the hex ASCII streamer.
interface hex_ascii_streamer_if #(
    parameter int VALUE_WIDTH = 32
);
    logic [VALUE_WIDTH-1:0] value_in;
    logic                   value_valid;
    logic                   value_ready;
    logic [7:0]             char_out;
    logic                   char_valid;
    logic                   char_ready;
    logic                   busy;

    modport master (
        input  value_in, value_valid, char_ready,
        output value_ready, char_out, char_valid, busy
    );

    modport slave (
        output value_in, value_valid, char_ready,
        input  value_ready, char_out, char_valid, busy
    );
endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational mapping of one hex nibble to its ASCII character.
module nibble_to_ascii
    import hex_ascii_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       lowercase,
    output logic [7:0] ascii
);
    logic [7:0] alpha_base;

    always_comb begin
        alpha_base = lowercase ? ASCII_LOWER_A : ASCII_UPPER_A;
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = alpha_base + {4'h0, nibble} - 8'd10;
        end
    end
endmodule

// File: rtl/hex_ascii_streamer.sv
// Captures a value and streams its hex ASCII digits MSB first over a byte handshake.
// Define HEX_STREAM_CRLF_EN to append CR then LF after the last digit.
module hex_ascii_streamer
    import hex_ascii_pkg::*;
#(
    parameter int VALUE_WIDTH    = 32,
    parameter int LOWERCASE      = 0,
    parameter int SUPPRESS_ZEROS = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    hex_ascii_streamer_if.master bus
);
    localparam int NDIG  = VALUE_WIDTH / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t                 state;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       lead_idx;
    logic [IDX_W-1:0]       start_idx;
    logic [3:0]             nib;
    logic [7:0]             ascii;
    logic                   capture;

    function automatic logic [3:0] nibble_at(input logic [VALUE_WIDTH-1:0] v,
                                             input logic [IDX_W-1:0] i);
        return 4'(v >> {i, 2'b00});
    endfunction

    // Highest non-zero nibble wins; an all-zero value still shows digit 0.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (nibble_at(bus.value_in, IDX_W'(i)) != 4'h0) lead_idx = IDX_W'(i);
        end
    end

    assign start_idx = (SUPPRESS_ZEROS != 0) ? lead_idx : IDX_LAST;
    assign capture   = (state == ST_IDLE) && bus.value_valid && bus.value_ready;

    // One converter: the first digit comes from the live input, later ones from the register.
    always_comb begin
        nib = 4'h0;
        if (state == ST_IDLE) begin
            nib = nibble_at(bus.value_in, start_idx);
        end else if (state == ST_DIGITS) begin
            nib = nibble_at(value_q, idx - IDX_ONE);
        end
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble    (nib),
        .lowercase (LOWERCASE != 0),
        .ascii     (ascii)
    );

    always_ff @(posedge clk) begin
        if (capture) value_q <= bus.value_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            idx             <= '0;
            bus.char_out    <= 8'h00;
            bus.char_valid  <= 1'b0;
            bus.value_ready <= 1'b1;
            bus.busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        idx             <= start_idx;
                        bus.char_out    <= ascii;
                        bus.char_valid  <= 1'b1;
                        bus.value_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= ST_DIGITS;
                    end
                end
                ST_DIGITS: begin
                    if (bus.char_ready) begin
                        if (idx == '0) begin
`ifdef HEX_STREAM_CRLF_EN
                            bus.char_out <= ASCII_CR;
                            state        <= ST_CR;
`else
                            bus.char_out    <= 8'h00;
                            bus.char_valid  <= 1'b0;
                            bus.value_ready <= 1'b1;
                            bus.busy        <= 1'b0;
                            state           <= ST_IDLE;
`endif
                        end else begin
                            idx          <= idx - IDX_ONE;
                            bus.char_out <= ascii;
                        end
                    end
                end
`ifdef HEX_STREAM_CRLF_EN
                ST_CR: begin
                    if (bus.char_ready) begin
                        bus.char_out <= ASCII_LF;
                        state        <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (bus.char_ready) begin
                        bus.char_out    <= 8'h00;
                        bus.char_valid  <= 1'b0;
                        bus.value_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Bench for hex_ascii_streamer: three configurations driven in parallel against a string-level model.
// Honours HEX_STREAM_CRLF_EN the same way as the design.
module tb_hex_ascii_streamer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: 32-bit upper, 1: 32-bit upper suppress zeros, 2: 16-bit lowercase.
    logic [63:0] vin    [3];
    logic        vvalid [3];
    logic        cready [3];
    logic [7:0]  cout   [3];
    logic        cvalid [3];
    logic        vready [3];
    logic        busy   [3];
    int          rdy_mode [3];

    hex_ascii_streamer_if #(.VALUE_WIDTH(32)) if_up  ();
    hex_ascii_streamer_if #(.VALUE_WIDTH(32)) if_sup ();
    hex_ascii_streamer_if #(.VALUE_WIDTH(16)) if_low ();

    hex_ascii_streamer #(.VALUE_WIDTH(32), .LOWERCASE(0), .SUPPRESS_ZEROS(0)) dut_up (
        .clk(clk), .reset_n(rst_n), .bus(if_up));
    hex_ascii_streamer #(.VALUE_WIDTH(32), .LOWERCASE(0), .SUPPRESS_ZEROS(1)) dut_sup (
        .clk(clk), .reset_n(rst_n), .bus(if_sup));
    hex_ascii_streamer #(.VALUE_WIDTH(16), .LOWERCASE(1), .SUPPRESS_ZEROS(0)) dut_low (
        .clk(clk), .reset_n(rst_n), .bus(if_low));

    assign if_up.value_in     = vin[0][31:0];
    assign if_up.value_valid  = vvalid[0];
    assign if_up.char_ready   = cready[0];
    assign cout[0]   = if_up.char_out;
    assign cvalid[0] = if_up.char_valid;
    assign vready[0] = if_up.value_ready;
    assign busy[0]   = if_up.busy;

    assign if_sup.value_in    = vin[1][31:0];
    assign if_sup.value_valid = vvalid[1];
    assign if_sup.char_ready  = cready[1];
    assign cout[1]   = if_sup.char_out;
    assign cvalid[1] = if_sup.char_valid;
    assign vready[1] = if_sup.value_ready;
    assign busy[1]   = if_sup.busy;

    assign if_low.value_in    = vin[2][15:0];
    assign if_low.value_valid = vvalid[2];
    assign if_low.char_ready  = cready[2];
    assign cout[2]   = if_low.char_out;
    assign cvalid[2] = if_low.char_valid;
    assign vready[2] = if_low.value_ready;
    assign busy[2]   = if_low.busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_buf [3][16];
    int         exp_len [3];
    int         exp_pos [3];
    logic [7:0] log_buf [3][256];
    int         log_cyc [3][256];
    int         log_len [3];
    int         cap_cnt [3];
    bit         stall_prev [3];
    logic [7:0] prev_char  [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int cfg_w(input int k);
        return (k == 2) ? 16 : 32;
    endfunction

    function automatic string crlf(input string s);
`ifdef HEX_STREAM_CRLF_EN
        return {s, "\015\012"};
`else
        return s;
`endif
    endfunction

    // Reference: spell the value in hex with a digit table, drop leading zeros if asked.
    task automatic load_expected(input int k, input logic [63:0] v);
        string digs;
        bit    lead;
        int    n;
        digs = (k == 2) ? "0123456789abcdef" : "0123456789ABCDEF";
        lead = (k == 1);
        exp_len[k] = 0;
        exp_pos[k] = 0;
        for (int d = cfg_w(k) / 4 - 1; d >= 0; d--) begin
            n = int'((v >> (4 * d)) & 64'hF);
            if (!(lead && n == 0 && d > 0)) begin
                lead = 1'b0;
                exp_buf[k][exp_len[k]] = digs[n];
                exp_len[k]++;
            end
        end
`ifdef HEX_STREAM_CRLF_EN
        exp_buf[k][exp_len[k]] = 8'h0D; exp_len[k]++;
        exp_buf[k][exp_len[k]] = 8'h0A; exp_len[k]++;
`endif
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(negedge clk) begin : mon
            bit act;
            if (!rst_n) begin
                exp_pos[g]    = 0;
                exp_len[g]    = 0;
                stall_prev[g] = 1'b0;
            end else begin
                act = (exp_pos[g] < exp_len[g]);
                chk(cvalid[g] == act, $sformatf("char_valid_%0d", g), cvalid[g], act);
                chk(vready[g] == !act, $sformatf("value_ready_%0d", g), vready[g], !act);
                chk(busy[g] == act, $sformatf("busy_%0d", g), busy[g], act);
                if (stall_prev[g])
                    chk(cout[g] == prev_char[g], $sformatf("stall_hold_%0d", g), cout[g], prev_char[g]);
                if (cvalid[g] && cready[g] && act) begin
                    chk(cout[g] == exp_buf[g][exp_pos[g]], $sformatf("char_%0d", g),
                        cout[g], exp_buf[g][exp_pos[g]]);
                    if (log_len[g] < 256) begin
                        log_buf[g][log_len[g]] = cout[g];
                        log_cyc[g][log_len[g]] = cyc;
                    end
                    log_len[g]++;
                    exp_pos[g]++;
                end
                if (vvalid[g] && vready[g] && !act) begin
                    load_expected(g, vin[g]);
                    cap_cnt[g]++;
                end
                stall_prev[g] = cvalid[g] && !cready[g];
                prev_char[g]  = cout[g];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            case (rdy_mode[k])
                0:       cready[k] = 1'b1;
                1:       cready[k] = ~cready[k];
                default: cready[k] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input int k, input logic [63:0] v);
        int t;
        @(posedge clk); #1;
        vin[k]    = v;
        vvalid[k] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (vready[k]) break;
            t++;
            if (t > 300) begin
                chk(1'b0, $sformatf("send_timeout_%0d", k), t, 300);
                vvalid[k] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        vvalid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (vready[k] && !cvalid[k]) break;
            t++;
            if (t > 500) begin
                chk(1'b0, $sformatf("idle_timeout_%0d", k), t, 500);
                return;
            end
        end
    endtask

    task automatic check_log(input int k, input int base, input string name, input string e);
        int n;
        n = log_len[k] - base;
        chk(n == e.len(), {name, "_len"}, n, e.len());
        for (int i = 0; i < e.len() && i < n; i++)
            chk(log_buf[k][base + i] == e[i], $sformatf("%s_c%0d", name, i), log_buf[k][base + i], e[i]);
    endtask

    task automatic rand_run(input int k);
        logic [63:0] v;
        for (int i = 0; i < 120; i++) begin
            v = {$urandom, $urandom};
            v = v >> (4 * $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) v = '0;
            v = (cfg_w(k) == 16) ? (v & 64'hFFFF) : (v & 64'hFFFF_FFFF);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(k, v);
        end
        wait_idle(k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    base;
        int    c0;
        int    t;
        string s2;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vin[k] = '0; vvalid[k] = 1'b0; rdy_mode[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(cvalid[k] == 1'b0, $sformatf("rst_char_valid_%0d", k), cvalid[k], 0);
            chk(cout[k] == 8'h00, $sformatf("rst_char_out_%0d", k), cout[k], 0);
            chk(vready[k] == 1'b1, $sformatf("rst_value_ready_%0d", k), vready[k], 1);
            chk(busy[k] == 1'b0, $sformatf("rst_busy_%0d", k), busy[k], 0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;

        base = log_len[0];
        send(0, 64'hDEADBEEF);
        wait_idle(0);
        check_log(0, base, "deadbeef", crlf("DEADBEEF"));
        chk(log_cyc[0][base + crlf("DEADBEEF").len() - 1] - log_cyc[0][base] == crlf("DEADBEEF").len() - 1,
            "deadbeef_back_to_back", log_cyc[0][base + crlf("DEADBEEF").len() - 1] - log_cyc[0][base],
            crlf("DEADBEEF").len() - 1);

        rdy_mode[0] = 1;
        base = log_len[0];
        send(0, 64'h0123ABCD);
        wait_idle(0);
        check_log(0, base, "toggle", crlf("0123ABCD"));
        rdy_mode[0] = 0;

        base = log_len[1];
        send(1, 64'h000000A5);
        wait_idle(1);
        check_log(1, base, "sup_a5", crlf("A5"));
        base = log_len[1];
        send(1, 64'h0);
        wait_idle(1);
        check_log(1, base, "sup_zero", crlf("0"));
        base = log_len[1];
        send(1, 64'h10000000);
        wait_idle(1);
        check_log(1, base, "sup_full", crlf("10000000"));

        base = log_len[2];
        send(2, 64'hF00D);
        wait_idle(2);
        check_log(2, base, "lower_f00d", crlf("f00d"));

        // value_valid stays high with a changing value while streaming
        base = log_len[0];
        c0   = cap_cnt[0];
        @(posedge clk); #1;
        vin[0] = 64'h11112222;
        vvalid[0] = 1'b1;
        @(negedge clk);
        for (t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (vready[0]) break;
            vin[0] = {32'h0, $urandom};
        end
        chk(t < 100, "held_timeout", t, 100);
        s2 = $sformatf("%08h", vin[0][31:0]);
        s2 = s2.toupper();
        @(posedge clk); #1;
        vvalid[0] = 1'b0;
        wait_idle(0);
        chk(cap_cnt[0] - c0 == 2, "held_captures", cap_cnt[0] - c0, 2);
        check_log(0, base, "held", {crlf("11112222"), crlf(s2)});

        // reset in the middle of a stream
        base = log_len[0];
        send(0, 64'h12345678);
        t = 0;
        while (log_len[0] - base < 3 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        chk(t < 100, "mid_rst_timeout", t, 100);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk(cvalid[0] == 1'b0, "mid_rst_char_valid", cvalid[0], 0);
        chk(cout[0] == 8'h00, "mid_rst_char_out", cout[0], 0);
        chk(vready[0] == 1'b1, "mid_rst_value_ready", vready[0], 1);
        chk(busy[0] == 1'b0, "mid_rst_busy", busy[0], 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        check_log(0, base, "mid_rst_part", "123");
        base = log_len[0];
        send(0, 64'h9ABCDEF0);
        wait_idle(0);
        check_log(0, base, "after_rst", crlf("9ABCDEF0"));
        chk(log_buf[0][base] == 8'h39, "after_rst_first", log_buf[0][base], 8'h39);

        for (int k = 0; k < 3; k++) rdy_mode[k] = 2;
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_ascii_streamer.md
# hex_ascii_streamer

Sequential successor to the combinational hex-to-ASCII converter. It captures a VALUE_WIDTH-bit value over a valid/ready handshake and emits its hexadecimal ASCII representation as a byte stream, one character per handshake, MSB nibble first. It sits between the register/diagnostic logic and the UART transmitter, replacing wide parallel ASCII buses with a single backpressured byte channel.

## Interface
- VALUE_WIDTH, 32, input width in bits; multiple of 4, range 4..64; NDIG = VALUE_WIDTH/4
- LOWERCASE, 0, 1 selects digits a-f (8'h61 base); 0 selects A-F (8'h41 base)
- SUPPRESS_ZEROS, 0, 1 omits leading zero digits; the least significant digit is always emitted

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- value_in  in  VALUE_WIDTH  value to display
- value_valid  in  1  value_in is valid
- value_ready  out  1  block idle and able to accept a value
- char_out  out  8  ASCII character
- char_valid  out  1  char_out is valid
- char_ready  in  1  downstream accepts char_out
- busy  out  1  a value is being streamed (inverse of value_ready)

## Operation
- States: IDLE, DIGITS, CR, LF (CR/LF present only with the macro).
- IDLE: value_ready=1. On value_valid && value_ready, register value_in, load digit index, and present the first character → DIGITS.
- Digit index: NDIG-1 normally; with SUPPRESS_ZEROS, the index of the most significant non-zero nibble, computed by a priority encoder at capture (0 if value is zero). No bubble cycles for skipped digits.
- Nibble mapping: 0-9 → 8'h30+n; 10-15 → base+(n-10), where base is 8'h41 or 8'h61. All arithmetic is 8-bit, no overflow possible.
- char_out/char_valid are registered. On char_valid && char_ready, the next character is presented on the following edge. When char_ready=0, char_out and char_valid hold stable.
- After the digit-0 handshake: → CR (macro) or → IDLE.
- value_valid while busy is ignored; the value is not captured until IDLE.

## Timing
- Reset values: char_out=8'h00, char_valid=0, value_ready=1, busy=0, state=IDLE.
- Capture on edge N → first character valid from edge N (char_valid high in cycle N+1).
- With char_ready held high, there is one character per cycle: NDIG (or fewer when suppressed) consecutive cycles, plus 2 for CR/LF.
- After the final character handshake at edge M: char_valid=0 and value_ready=1 in cycle M+1. A new capture is possible at edge M+1, so there is a minimum one-cycle gap between values.
- Reset asserted mid-stream: outputs go to reset values immediately and the pending characters are discarded. After deassertion the block is IDLE, and the next value streams from its first digit.

## Configuration
- HEX_STREAM_CRLF_EN defined: after the last digit the block emits 8'h0D (CR) then 8'h0A (LF), each under the same handshake, then → IDLE.
- Not defined: the CR and LF states and logic are absent, and the block returns to IDLE directly after the last digit.

## Structure
- Package hex_ascii_pkg holds:
  - ASCII constants: ASCII_ZERO=8'h30, ASCII_UPPER_A=8'h41, ASCII_LOWER_A=8'h61, ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - state enum
- Sub-module nibble_to_ascii: combinational, 4-bit nibble plus lowercase select → 8-bit character. It is instantiated once, on the muxed current nibble.
- Top level holds the FSM, value register, digit counter and leading-zero priority encoder.

## Test plan
- VALUE_WIDTH=32, 32'hDEADBEEF, char_ready=1 → 44 45 41 44 42 45 45 46 on 8 consecutive cycles (then 0D 0A with macro); value_ready=1 the cycle after the last handshake.
- 32'h0123ABCD with char_ready toggling each cycle → sequence 30 31 32 33 41 42 43 44; char_out stable during every stall cycle.
- SUPPRESS_ZEROS=1: 32'h000000A5 → 41 35 only. 32'h00000000 → single 30. 32'h10000000 → all 8 digits.
- LOWERCASE=1, VALUE_WIDTH=16, 16'hF00D → 66 30 30 64.
- Reset asserted after 3 characters of 32'h12345678 → char_valid=0 asynchronously. After release, capture 32'h9ABCDEF0 → stream starts at 39.
- value_valid held high with a changing value_in during streaming → ignored; the value present in the first IDLE cycle is captured.
